// File: rtl/audio_viz_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audio_viz_pkg
// Brief    : Shared FSM state type and default frame/FFT constants.
// Revision : 1.0
// ============================================================================
package audio_viz_pkg;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        KICK = 3'd2,
        WAIT = 3'd3,
        HOLD = 3'd4
    } state_t;

    localparam int C_N_POINTS    = 256;
    localparam int C_SAMPLE_W    = 24;
    localparam int C_FFT_TIMEOUT = 4096;
endpackage
`default_nettype wire

// File: rtl/fft_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_ctrl_if
// Brief    : Sample stream, FFT buffer and display handshake bundle.
// Revision : 1.0
// ============================================================================
interface fft_frame_ctrl_if
    import audio_viz_pkg::*;
#(
    parameter int N_POINTS = C_N_POINTS,
    parameter int SAMPLE_W = C_SAMPLE_W
);
    localparam int ADDR_W = $clog2(N_POINTS);

    logic                trig;
    logic                cont_mode;
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample_in;
    logic                buf_we;
    logic [ADDR_W-1:0]   buf_addr;
    logic [SAMPLE_W-1:0] buf_wdata;
    logic                fft_start;
    logic                fft_done;
    logic                frame_ready;
    logic                frame_ack;
    logic                busy;
    logic                err;
    logic                err_clr;
    logic [15:0]         drop_cnt;

    modport master (
        output trig, cont_mode, sample_valid, sample_in, fft_done, frame_ack, err_clr,
        input  buf_we, buf_addr, buf_wdata, fft_start, frame_ready, busy, err, drop_cnt
    );

    modport slave (
        input  trig, cont_mode, sample_valid, sample_in, fft_done, frame_ack, err_clr,
        output buf_we, buf_addr, buf_wdata, fft_start, frame_ready, busy, err, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at all-ones instead of wrapping.
// Revision : 1.0
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             inc,
    input  wire logic             clr,
    output logic [WIDTH-1:0]      count
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_ctrl
// Brief    : Captures N_POINTS samples into the FFT buffer, kicks the FFT,
//            waits for completion with timeout and holds the frame for display.
// Revision : 1.0
// ============================================================================
module fft_frame_ctrl
    import audio_viz_pkg::*;
#(
    parameter int N_POINTS    = C_N_POINTS,
    parameter int SAMPLE_W    = C_SAMPLE_W,
    parameter int FFT_TIMEOUT = C_FFT_TIMEOUT
) (
    input  wire logic       clk,
    input  wire logic       rst,
    fft_frame_ctrl_if.slave bus
);
    localparam int ADDR_W = $clog2(N_POINTS);
    localparam int TMO_W  = $clog2(FFT_TIMEOUT);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [TMO_W-1:0]    r_tmo_cnt;
    logic                r_buf_we;
    logic [ADDR_W-1:0]   r_buf_addr;
    logic [SAMPLE_W-1:0] r_buf_wdata;
    logic                r_fft_start;
    logic                r_frame_ready;
    logic                r_err;
    logic                w_accept;
    logic                w_last;
    logic                w_done;
    logic                w_timeout;
    logic                w_ack;
    logic                w_drop;

    always_comb begin
        w_accept  = (r_state == FILL) && bus.sample_valid;
        w_last    = w_accept && (r_wr_addr == ADDR_W'(N_POINTS - 1));
        w_done    = (r_state == WAIT) && bus.fft_done;
        // Done has priority: a timeout is only declared without a coincident done.
        w_timeout = (r_state == WAIT) && !bus.fft_done
                    && (r_tmo_cnt == TMO_W'(FFT_TIMEOUT - 1));
        w_ack     = (r_state == HOLD) && bus.frame_ack;
        w_drop    = bus.sample_valid
                    && ((r_state == KICK) || (r_state == WAIT) || (r_state == HOLD));
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.trig || bus.cont_mode) w_next = FILL;
            FILL:    if (w_last) w_next = KICK;
            KICK:    w_next = WAIT;
            WAIT:    if (w_done) w_next = HOLD;
                     else if (w_timeout) w_next = IDLE;
            HOLD:    if (w_ack) w_next = bus.cont_mode ? FILL : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Counter is zero during KICK, so the abort lands FFT_TIMEOUT cycles after fft_start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_addr <= '0;
            r_tmo_cnt <= '0;
        end else begin
            if (r_state != FILL) r_wr_addr <= '0;
            else if (w_accept)   r_wr_addr <= r_wr_addr + 1'b1;
            if ((r_state == KICK) || (r_state == WAIT)) r_tmo_cnt <= r_tmo_cnt + 1'b1;
            else                                        r_tmo_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_we      <= 1'b0;
            r_buf_addr    <= '0;
            r_buf_wdata   <= '0;
            r_fft_start   <= 1'b0;
            r_frame_ready <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_buf_we    <= w_accept;
            r_fft_start <= w_last;
            if (w_accept) begin
                r_buf_addr  <= r_wr_addr;
                r_buf_wdata <= bus.sample_in;
            end
            if (w_done)     r_frame_ready <= 1'b1;
            else if (w_ack) r_frame_ready <= 1'b0;
            if (w_timeout)        r_err <= 1'b1;
            else if (bus.err_clr) r_err <= 1'b0;
        end
    end

    sat_counter #(.WIDTH(16)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_drop),
        .clr   (1'b0),
        .count (bus.drop_cnt)
    );

    assign bus.buf_we      = r_buf_we;
    assign bus.buf_addr    = r_buf_addr;
    assign bus.buf_wdata   = r_buf_wdata;
    assign bus.fft_start   = r_fft_start;
    assign bus.frame_ready = r_frame_ready;
    assign bus.err         = r_err;
    assign bus.busy        = (r_state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_frame_ctrl
// Brief    : Scenario bench for fft_frame_ctrl with N_POINTS=8, FFT_TIMEOUT=16.
// Revision : 1.0
// ============================================================================
module tb_fft_frame_ctrl;
    localparam int N_POINTS    = 8;
    localparam int SAMPLE_W    = 24;
    localparam int FFT_TIMEOUT = 16;

    typedef struct packed {
        logic [2:0]          addr;
        logic [SAMPLE_W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;
    int   wr_cnt  = 0;
    int   start_cnt = 0;
    int   exp_addr = 0;
    wr_t  exp_q[$];

    fft_frame_ctrl_if #(.N_POINTS(N_POINTS), .SAMPLE_W(SAMPLE_W)) bus ();

    fft_frame_ctrl #(
        .N_POINTS    (N_POINTS),
        .SAMPLE_W    (SAMPLE_W),
        .FFT_TIMEOUT (FFT_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard: every buffer write must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.fft_start === 1'b1) start_cnt++;
        if (bus.buf_we === 1'b1) begin
            wr_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, none expected",
                         bus.buf_addr, bus.buf_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.buf_addr !== e.addr || bus.buf_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%h, want addr=%0d data=%h",
                             bus.buf_addr, bus.buf_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives count samples (gap idle cycles before each) while the DUT is in FILL.
    task automatic fill_frame(input int base, input int gap, input int count);
        for (int i = 0; i < count; i++) begin
            bus.sample_valid = 1'b0;
            repeat (gap) tick();
            bus.sample_valid = 1'b1;
            bus.sample_in    = SAMPLE_W'(base + i);
            exp_q.push_back('{addr: 3'(exp_addr), data: SAMPLE_W'(base + i)});
            exp_addr++;
            tick();
        end
        bus.sample_valid = 1'b0;
    endtask

    task automatic pulse_trig();
        exp_addr = 0;
        bus.trig = 1'b1;
        tick();
        bus.trig = 1'b0;
    endtask

    task automatic finish_frame();
        tick();
        bus.fft_done = 1'b1;
        tick();
        bus.fft_done  = 1'b0;
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
    endtask

    task automatic test_reset();
        bus.trig = 0; bus.cont_mode = 0; bus.sample_valid = 0; bus.sample_in = '0;
        bus.fft_done = 0; bus.frame_ack = 0; bus.err_clr = 0;
        rst = 1'b1;
        repeat (2) tick();
        vectors++;
        if ({bus.buf_we, bus.buf_addr, bus.buf_wdata, bus.fft_start, bus.frame_ready,
             bus.busy, bus.err, bus.drop_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b addr=%0d wd=%h st=%b rdy=%b busy=%b err=%b drop=%0d, want all 0",
                     bus.buf_we, bus.buf_addr, bus.buf_wdata, bus.fft_start, bus.frame_ready,
                     bus.busy, bus.err, bus.drop_cnt);
        end
        rst = 1'b0;
        bus.sample_valid = 1'b1;
        repeat (3) tick();
        bus.sample_valid = 1'b0;
        vectors++;
        if (bus.drop_cnt !== 16'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_samples: got drop=%0d busy=%b, want 0 0", bus.drop_cnt, bus.busy);
        end
    endtask

    task automatic test_single_shot();
        int s0 = start_cnt;
        int w0 = wr_cnt;
        pulse_trig();
        fill_frame(1, 0, 8);
        vectors++;
        if (bus.fft_start !== 1'b1 || bus.buf_we !== 1'b1 || bus.buf_addr !== 3'd7) begin
            errors++;
            $display("FAIL single_kick: got st=%b we=%b addr=%0d, want 1 1 7",
                     bus.fft_start, bus.buf_we, bus.buf_addr);
        end
        tick();
        vectors++;
        if (bus.fft_start !== 1'b0) begin
            errors++;
            $display("FAIL single_start_width: got %b, want 0", bus.fft_start);
        end
        repeat (4) tick();
        bus.fft_done = 1'b1;
        tick();
        bus.fft_done = 1'b0;
        vectors++;
        if (bus.frame_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: got %b, want 1", bus.frame_ready);
        end
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
        vectors++;
        if (bus.frame_ready !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: got rdy=%b busy=%b, want 0 0", bus.frame_ready, bus.busy);
        end
        vectors++;
        if (start_cnt - s0 != 1 || wr_cnt - w0 != 8) begin
            errors++;
            $display("FAIL single_counts: got starts=%0d writes=%0d, want 1 8",
                     start_cnt - s0, wr_cnt - w0);
        end
    endtask

    task automatic test_gapped();
        int s0 = start_cnt;
        int w0 = wr_cnt;
        pulse_trig();
        fill_frame(24'h10, 2, 8);
        vectors++;
        if (bus.fft_start !== 1'b1) begin
            errors++;
            $display("FAIL gapped_kick: got %b, want 1", bus.fft_start);
        end
        finish_frame();
        repeat (3) tick();
        vectors++;
        if (start_cnt - s0 != 1 || wr_cnt - w0 != 8) begin
            errors++;
            $display("FAIL gapped_counts: got starts=%0d writes=%0d, want 1 8",
                     start_cnt - s0, wr_cnt - w0);
        end
    endtask

    task automatic test_ignored();
        int s0 = start_cnt;
        pulse_trig();
        fill_frame(24'h40, 0, 3);
        bus.trig = 1'b1;
        fill_frame(24'h43, 0, 1);
        bus.trig     = 1'b0;
        bus.fft_done = 1'b1;
        tick();
        bus.fft_done  = 1'b0;
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1 || bus.frame_ready !== 1'b0 || bus.fft_start !== 1'b0) begin
            errors++;
            $display("FAIL ignored_in_fill: got busy=%b rdy=%b st=%b, want 1 0 0",
                     bus.busy, bus.frame_ready, bus.fft_start);
        end
        fill_frame(24'h44, 0, 4);
        vectors++;
        if (bus.fft_start !== 1'b1) begin
            errors++;
            $display("FAIL ignored_kick: got %b, want 1", bus.fft_start);
        end
        tick();
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
        vectors++;
        if (bus.frame_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL ignored_ack_in_wait: got rdy=%b busy=%b, want 0 1",
                     bus.frame_ready, bus.busy);
        end
        finish_frame();
        vectors++;
        if (start_cnt - s0 != 1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_starts: got starts=%0d busy=%b, want 1 0",
                     start_cnt - s0, bus.busy);
        end
    endtask

    task automatic test_timeout();
        pulse_trig();
        fill_frame(24'h80, 0, 8);
        repeat (15) tick();
        vectors++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: got err=%b busy=%b, want 0 1", bus.err, bus.busy);
        end
        tick();
        vectors++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort: got err=%b busy=%b, want 1 0", bus.err, bus.busy);
        end
        repeat (2) tick();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        vectors++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: got %b, want 0", bus.err);
        end
        pulse_trig();
        fill_frame(24'h90, 0, 8);
        repeat (15) tick();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        vectors++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_vs_clr: got err=%b busy=%b, want 1 0", bus.err, bus.busy);
        end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        pulse_trig();
        fill_frame(24'hA0, 0, 8);
        repeat (15) tick();
        bus.fft_done = 1'b1;
        tick();
        bus.fft_done = 1'b0;
        vectors++;
        if (bus.frame_ready !== 1'b1 || bus.err !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL done_vs_timeout: got rdy=%b err=%b busy=%b, want 1 0 1",
                     bus.frame_ready, bus.err, bus.busy);
        end
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
    endtask

    task automatic test_continuous();
        bus.cont_mode = 1'b1;
        exp_addr = 0;
        tick();
        vectors++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL cont_autostart: got busy=%b, want 1", bus.busy);
        end
        fill_frame(24'h100, 0, 8);
        bus.sample_valid = 1'b1;
        repeat (3) tick();
        bus.sample_valid = 1'b0;
        vectors++;
        if (bus.drop_cnt !== 16'd3) begin
            errors++;
            $display("FAIL drop_kick_wait: got %0d, want 3", bus.drop_cnt);
        end
        bus.fft_done = 1'b1;
        tick();
        bus.fft_done     = 1'b0;
        bus.sample_valid = 1'b1;
        repeat (2) tick();
        bus.sample_valid = 1'b0;
        vectors++;
        if (bus.drop_cnt !== 16'd5 || bus.frame_ready !== 1'b1) begin
            errors++;
            $display("FAIL drop_hold: got drop=%0d rdy=%b, want 5 1", bus.drop_cnt, bus.frame_ready);
        end
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1 || bus.frame_ready !== 1'b0) begin
            errors++;
            $display("FAIL cont_rearm: got busy=%b rdy=%b, want 1 0", bus.busy, bus.frame_ready);
        end
        exp_addr = 0;
        fill_frame(24'h200, 0, 8);
        tick();
        bus.fft_done = 1'b1;
        tick();
        bus.fft_done     = 1'b0;
        bus.cont_mode    = 1'b0;
        bus.sample_valid = 1'b1;
        repeat (70000) tick();
        bus.sample_valid = 1'b0;
        vectors++;
        if (bus.drop_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL drop_saturate: got %h, want ffff", bus.drop_cnt);
        end
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL cont_stop: got busy=%b, want 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid_fill();
        pulse_trig();
        fill_frame(24'h300, 0, 4);
        #5;
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.buf_we, bus.buf_addr, bus.buf_wdata, bus.fft_start, bus.frame_ready,
             bus.busy, bus.err, bus.drop_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset: got we=%b addr=%0d wd=%h st=%b rdy=%b busy=%b err=%b drop=%0d, want all 0",
                     bus.buf_we, bus.buf_addr, bus.buf_wdata, bus.fft_start, bus.frame_ready,
                     bus.busy, bus.err, bus.drop_cnt);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_pending_writes: got %0d, want 0", exp_q.size());
            exp_q.delete();
        end
        tick();
        rst = 1'b0;
        tick();
        pulse_trig();
        fill_frame(24'h400, 0, 8);
        vectors++;
        if (bus.fft_start !== 1'b1) begin
            errors++;
            $display("FAIL restart_kick: got %b, want 1", bus.fft_start);
        end
        finish_frame();
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_gapped();
        test_ignored();
        test_timeout();
        test_continuous();
        test_reset_mid_fill();
        repeat (3) tick();
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes: got %0d outstanding, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer between the audio sample stream and the FFT core. A one-cycle trigger pulse from the user-input debouncer starts a capture, or continuous mode starts captures back-to-back. The block writes N_POINTS consecutive valid samples into the FFT input buffer, then pulses the FFT start. It waits for FFT completion with a timeout and holds the frame for the display side until acknowledged.

## Interface
- N_POINTS, 256: samples per frame; power of two, ≥ 4
- SAMPLE_W, 24: audio sample width
- FFT_TIMEOUT, 4096: max cycles spent in WAIT before abort
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- trig  in  1  one-cycle capture request (from debouncer)
- cont_mode  in  1  1 = re-arm automatically after each frame
- sample_valid  in  1  sample_in valid this cycle
- sample_in  in  SAMPLE_W  audio sample
- buf_we  out  1  FFT input buffer write enable (registered)
- buf_addr  out  log2(N_POINTS)  buffer write address (registered)
- buf_wdata  out  SAMPLE_W  buffer write data (registered)
- fft_start  out  1  one-cycle FFT start pulse (registered)
- fft_done  in  1  one-cycle FFT completion pulse
- frame_ready  out  1  FFT result valid for display (registered)
- frame_ack  in  1  display has consumed frame
- busy  out  1  state ≠ IDLE
- err  out  1  sticky FFT timeout flag
- err_clr  in  1  clears err
- drop_cnt  out  16  saturating count of samples dropped while busy

## Operation
- States: IDLE, FILL, KICK, WAIT, HOLD.
- IDLE: if trig or cont_mode, go to FILL and set wr_addr = 0. Samples are ignored and not counted.
- FILL: each cycle with sample_valid, register buf_we = 1, buf_addr = wr_addr, buf_wdata = sample_in, then increment wr_addr. On acceptance at wr_addr = N_POINTS−1, go to KICK. No wrap occurs within a frame.
- KICK: fft_start = 1 for exactly one cycle, clear the timeout counter, go to WAIT.
- WAIT: count cycles. On fft_done, go to HOLD with frame_ready = 1. If the count reaches FFT_TIMEOUT−1 without fft_done, set err and go to IDLE. If fft_done and timeout occur in the same cycle, done wins.
- HOLD: frame_ready stays 1 until frame_ack. On ack, frame_ready drops next cycle; go to FILL (wr_addr = 0) if cont_mode, else IDLE.
- fft_done is ignored outside WAIT. frame_ack is ignored outside HOLD. trig is ignored while busy.
- sample_valid in KICK, WAIT or HOLD increments drop_cnt, which saturates at 0xFFFF and never wraps.
- err_clr clears err. If err_clr and a timeout coincide, err ends at 1 (set wins).
- RST at any time: state IDLE; wr_addr, timeout counter and drop_cnt = 0; all outputs 0. An in-flight frame is abandoned and the buffer contents are don't-care.

## Timing
- Reset values: buf_we, buf_addr, buf_wdata, fft_start, frame_ready, busy, err, drop_cnt = 0.
- Trig accepted at cycle t: state FILL at t+1, and a sample valid at t+1 is written.
- A sample accepted at cycle t appears on buf_we/addr/wdata at t+1. Exactly one write occurs per accepted sample.
- Last sample accepted at t: last buf_we at t+1 and fft_start at t+1, since the KICK state is entered at t+1. The buffer write commits on the same edge the FFT samples fft_start, so the FFT core must begin reading at least one cycle after start.
- fft_done at t: frame_ready = 1 at t+1.
- frame_ack at t (in HOLD): frame_ready = 0 and state FILL/IDLE at t+1.
- Gapped sample_valid is legal. Frame length is always exactly N_POINTS accepted samples.

## Structure
- Shared package audio_viz_pkg holds:
  - typedef enum for states {IDLE, FILL, KICK, WAIT, HOLD};
  - default N_POINTS, SAMPLE_W and FFT_TIMEOUT constants.
- Sub-module sat_counter (parameter WIDTH; ports CLK, RST, inc, clr, count) implements drop_cnt.
- The FSM, address counter and timeout counter stay in fft_frame_ctrl.

## Test plan
All scenarios use N_POINTS = 8 and FFT_TIMEOUT = 16.
- Single shot: trig pulse, then 8 contiguous valid samples 0x1..0x8 → buf_addr 0..7 with matching data, one fft_start the cycle after the last accepted sample; fft_done 5 cycles later → frame_ready, ack → IDLE, busy = 0.
- Gapped input: valid every third cycle → exactly 8 writes at addresses 0..7, no extra writes, fft_start after the 8th.
- Continuous mode: cont_mode = 1 with no trig → FILL from IDLE; after ack, a new frame starts at buf_addr 0. Samples during WAIT/HOLD increment drop_cnt; 70 000 dropped samples → drop_cnt = 0xFFFF.
- Timeout: no fft_done → err = 1 and state IDLE exactly 16 cycles after fft_start; err_clr → err = 0; done and timeout in the same cycle → HOLD, err = 0.
- Ignored events: trig during FILL, fft_done during FILL, frame_ack during WAIT → no state change, no extra fft_start.
- Reset mid-FILL (after 4 samples): all outputs 0 immediately (asynchronous); next trig restarts at buf_addr 0.
